fetch_byte_queue: RTL and testbench

// - Byte-granular instruction queue that feeds the decode stage: buffers aligned 8-byte fetch

---
 rtl/fetch_byte_queue.sv | 165 ++++++++++++++++
 tb/tb_fetch_byte_queue.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_byte_queue.sv
// Byte-granular instruction queue between fetch and decode.
// Buffers aligned fetch lines and presents a left-aligned decode window.
module fetch_byte_queue #(
  parameter int FETCH_BYTES  = 8,
  parameter int QUEUE_BYTES  = 32,
  parameter int WINDOW_BYTES = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic [63:0]               flush_pc,
  output logic                      req_valid,
  output logic [63:0]               req_addr,
  input  logic                      req_ready,
  input  logic                      rsp_valid,
  input  logic [63:0]               rsp_data,
  output logic [0:WINDOW_BYTES*8-1] win_bytes,
  output logic [4:0]                win_count,
  output logic [63:0]               win_pc,
  input  logic                      consume_valid,
  input  logic [4:0]                consume_cnt,
  output logic                      err
);

  localparam int QW = $clog2(QUEUE_BYTES);
  localparam int FW = $clog2(FETCH_BYTES);
  localparam int CW = QW + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } state_t;

  state_t         state, state_n;
  logic [7:0]     q   [QUEUE_BYTES];
  logic [7:0]     q_n [QUEUE_BYTES];
  logic [QW-1:0]  head, head_n;
  logic [CW-1:0]  count, count_n;
  logic [63:0]    fetch_pc, fetch_pc_n;
  logic [63:0]    win_pc_n;
  logic [FW-1:0]  skip, skip_n;
  logic           err_n;
  logic           flushed_once, flushed_n;
  logic [4:0]     wc_n;
  logic [0:WINDOW_BYTES*8-1] wb_n;

  logic           cons_ok;
  logic           rsp_take;
  logic [QW-1:0]  tail;
  logic [CW-1:0]  space;

  assign req_valid = (state == REQ);
  assign req_addr  = fetch_pc;

  assign cons_ok  = consume_valid && (consume_cnt != 5'd0)
                 && (consume_cnt <= win_count);
  assign rsp_take = rsp_valid && (state == WAIT);
  assign tail     = head + count[QW-1:0];
  assign space    = CW'(QUEUE_BYTES) - count;

  always_comb begin
    q_n        = q;
    head_n     = head;
    count_n    = count;
    fetch_pc_n = fetch_pc;
    win_pc_n   = win_pc;
    skip_n     = skip;
    err_n      = err;
    flushed_n  = flushed_once;
    state_n    = state;
    if (flush) begin
      head_n     = '0;
      count_n    = '0;
      win_pc_n   = flush_pc;
      fetch_pc_n = {flush_pc[63:FW], FW'(0)};
      skip_n     = flush_pc[FW-1:0];
      err_n      = 1'b0;
      flushed_n  = 1'b1;
      // An in-flight line must be discarded unless it lands this cycle.
      unique case (state)
        IDLE: state_n = IDLE;
        REQ:  state_n = req_ready ? DROP : IDLE;
        WAIT: state_n = rsp_valid ? IDLE : DROP;
        DROP: state_n = rsp_valid ? IDLE : DROP;
        default: state_n = IDLE;
      endcase
    end else begin
      if (consume_valid && (consume_cnt > win_count))
        err_n = 1'b1;
      if (cons_ok) begin
        head_n   = head + QW'(consume_cnt);
        count_n  = count - CW'(consume_cnt);
        win_pc_n = win_pc + 64'(consume_cnt);
      end
      if (rsp_take) begin
        for (int j = 0; j < FETCH_BYTES; j++)
          if (j >= int'(skip))
            q_n[tail + QW'(j) - QW'(skip)] = rsp_data[j*8 +: 8];
        count_n = count_n + CW'(FETCH_BYTES) - CW'(skip);
        skip_n  = '0;
      end
      unique case (state)
        IDLE:
          if (flushed_once && space >= CW'(FETCH_BYTES))
            state_n = REQ;
        REQ:
          if (req_ready) begin
            state_n    = WAIT;
            fetch_pc_n = fetch_pc + 64'(FETCH_BYTES);
          end
        WAIT:
          if (rsp_valid) state_n = IDLE;
        DROP:
          if (rsp_valid) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    wb_n = '0;
    wc_n = (count_n > CW'(WINDOW_BYTES)) ? 5'(WINDOW_BYTES)
                                         : 5'(count_n);
    for (int k = 0; k < WINDOW_BYTES; k++)
      if (k < int'(wc_n))
        wb_n[k*8 +: 8] = q_n[head_n + QW'(k)];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < QUEUE_BYTES; i++)
        q[i] <= '0;
      state        <= IDLE;
      head         <= '0;
      count        <= '0;
      fetch_pc     <= '0;
      win_pc       <= '0;
      skip         <= '0;
      err          <= 1'b0;
      flushed_once <= 1'b0;
      win_count    <= '0;
      win_bytes    <= '0;
    end else begin
      q            <= q_n;
      state        <= state_n;
      head         <= head_n;
      count        <= count_n;
      fetch_pc     <= fetch_pc_n;
      win_pc       <= win_pc_n;
      skip         <= skip_n;
      err          <= err_n;
      flushed_once <= flushed_n;
      win_count    <= wc_n;
      win_bytes    <= wb_n;
    end
  end

  rsp_in_window: assert property (
    @(posedge clk) disable iff (!reset_n)
    rsp_valid |-> (state == WAIT || state == DROP)
  );

endmodule

// File: tb/tb_fetch_byte_queue.sv
// Directed bench for fetch_byte_queue: table of consume vectors
// plus hand-written fetch/flush/drop sequences.
module tb_fetch_byte_queue;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         flush;
  logic [63:0]  flush_pc;
  logic         req_valid;
  logic [63:0]  req_addr;
  logic         req_ready;
  logic         rsp_valid;
  logic [63:0]  rsp_data;
  logic [0:127] win_bytes;
  logic [4:0]   win_count;
  logic [63:0]  win_pc;
  logic         consume_valid;
  logic [4:0]   consume_cnt;
  logic         err;

  int n_cmp = 0;
  int n_mis = 0;

  fetch_byte_queue dut (
    .clk(clk), .reset_n(reset_n),
    .flush(flush), .flush_pc(flush_pc),
    .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .win_bytes(win_bytes), .win_count(win_count),
    .win_pc(win_pc),
    .consume_valid(consume_valid),
    .consume_cnt(consume_cnt), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        cv;
    logic [4:0]  cnt;
    logic [4:0]  wc;
    logic [63:0] pc;
    logic [7:0]  b0;
    logic        er;
  } vec_t;

  vec_t vecs [7];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] wbyte(input int k);
    return win_bytes[k*8 +: 8];
  endfunction

  function automatic logic [63:0] line(input logic [63:0] a);
    logic [63:0] d;
    for (int k = 0; k < 8; k++)
      d[k*8 +: 8] = a[7:0] + 8'(k);
    return d;
  endfunction

  task automatic do_flush(input logic [63:0] pc);
    flush    = 1'b1;
    flush_pc = pc;
    tick;
    flush    = 1'b0;
  endtask

  task automatic wait_req(input logic [63:0] a);
    int w = 0;
    while (!req_valid && w < 20) begin
      tick;
      w++;
    end
    chk("req_seen", {63'd0, req_valid}, 64'd1);
    chk("req_addr", req_addr, a);
  endtask

  task automatic fetch(input logic [63:0] a,
                       input logic [4:0] cons);
    wait_req(a);
    req_ready = 1'b1;
    tick;
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_data  = line(a);
    if (cons != 5'd0) begin
      consume_valid = 1'b1;
      consume_cnt   = cons;
    end
    tick;
    rsp_valid     = 1'b0;
    consume_valid = 1'b0;
  endtask

  initial begin
    logic idle_ok;
    reset_n = 1'b0;
    flush = 1'b0;
    flush_pc = '0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data = '0;
    consume_valid = 1'b0;
    consume_cnt = '0;

    vecs[0] = '{1'b1, 5'd5,  5'd16, 64'h100D, 8'h0D, 1'b0};
    vecs[1] = '{1'b1, 5'd0,  5'd16, 64'h100D, 8'h0D, 1'b0};
    vecs[2] = '{1'b0, 5'd7,  5'd16, 64'h100D, 8'h0D, 1'b0};
    vecs[3] = '{1'b1, 5'd16, 5'd11, 64'h101D, 8'h1D, 1'b0};
    vecs[4] = '{1'b1, 5'd10, 5'd1,  64'h1027, 8'h27, 1'b0};
    vecs[5] = '{1'b1, 5'd2,  5'd1,  64'h1027, 8'h27, 1'b1};
    vecs[6] = '{1'b1, 5'd1,  5'd0,  64'h1028, 8'h00, 1'b1};

    tick;
    tick;
    chk("rst_wc", 64'(win_count), 64'd0);
    chk("rst_pc", win_pc, 64'd0);
    chk("rst_req", 64'(req_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_win", win_bytes[0:63], 64'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) tick;
    chk("no_req_before_flush", 64'(req_valid), 64'd0);

    do_flush(64'h1000);
    fetch(64'h1000, 5'd0);
    chk("f0_wc", 64'(win_count), 64'd8);
    chk("f0_pc", win_pc, 64'h1000);
    chk("f0_b0", 64'(wbyte(0)), 64'h00);
    chk("f0_bytes", win_bytes[0:63], 64'h0001020304050607);
    chk("f0_b8", 64'(wbyte(8)), 64'h00);

    fetch(64'h1008, 5'd0);
    fetch(64'h1010, 5'd0);
    fetch(64'h1018, 5'd0);
    idle_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (req_valid) idle_ok = 1'b0;
    end
    chk("full_no_req", 64'(idle_ok), 64'd1);
    chk("full_wc", 64'(win_count), 64'd16);
    chk("full_b15", 64'(wbyte(15)), 64'h0F);

    consume_valid = 1'b1;
    consume_cnt   = 5'd8;
    tick;
    consume_valid = 1'b0;
    chk("c8_req_late", 64'(req_valid), 64'd0);
    chk("c8_pc", win_pc, 64'h1008);
    tick;
    chk("c8_req", 64'(req_valid), 64'd1);
    fetch(64'h1020, 5'd0);
    chk("refill_wc", 64'(win_count), 64'd16);
    chk("refill_b0", 64'(wbyte(0)), 64'h08);
    chk("refill_b15", 64'(wbyte(15)), 64'h17);
    tick;
    chk("refill_no_req", 64'(req_valid), 64'd0);

    foreach (vecs[i]) begin
      consume_valid = vecs[i].cv;
      consume_cnt   = vecs[i].cnt;
      tick;
      consume_valid = 1'b0;
      chk($sformatf("vec%0d_wc", i), 64'(win_count), 64'(vecs[i].wc));
      chk($sformatf("vec%0d_pc", i), win_pc, vecs[i].pc);
      chk($sformatf("vec%0d_b0", i), 64'(wbyte(0)), 64'(vecs[i].b0));
      chk($sformatf("vec%0d_err", i), 64'(err), 64'(vecs[i].er));
    end

    do_flush(64'h1005);
    chk("flush_clr_err", 64'(err), 64'd0);
    fetch(64'h1000, 5'd0);
    chk("skip_wc", 64'(win_count), 64'd3);
    chk("skip_pc", win_pc, 64'h1005);
    chk("skip_bytes", 64'(win_bytes[0:31]), 64'h05060700);

    do_flush(64'h1006);
    fetch(64'h1000, 5'd0);
    fetch(64'h1008, 5'd0);
    chk("pre_cr_wc", 64'(win_count), 64'd10);
    fetch(64'h1010, 5'd3);
    chk("cr_wc", 64'(win_count), 64'd15);
    chk("cr_pc", win_pc, 64'h1009);
    chk("cr_b0", 64'(wbyte(0)), 64'h09);
    chk("cr_b14", 64'(wbyte(14)), 64'h17);
    chk("cr_b15", 64'(wbyte(15)), 64'h00);

    do_flush(64'h1000);
    fetch(64'h1000, 5'd0);
    wait_req(64'h1008);
    req_ready = 1'b1;
    tick;
    req_ready = 1'b0;
    do_flush(64'h2000);
    chk("drop_req", 64'(req_valid), 64'd0);
    chk("drop_wc", 64'(win_count), 64'd0);
    chk("drop_pc", win_pc, 64'h2000);
    rsp_valid = 1'b1;
    rsp_data  = line(64'h1008);
    tick;
    rsp_valid = 1'b0;
    chk("stale_wc", 64'(win_count), 64'd0);
    fetch(64'h2000, 5'd0);
    chk("redir_wc", 64'(win_count), 64'd8);
    chk("redir_b0", 64'(wbyte(0)), 64'h00);

    do_flush(64'h2004);
    fetch(64'h2000, 5'd0);
    chk("e_wc", 64'(win_count), 64'd4);
    consume_valid = 1'b1;
    consume_cnt   = 5'd5;
    tick;
    consume_valid = 1'b0;
    chk("e_err", 64'(err), 64'd1);
    chk("e_wc_hold", 64'(win_count), 64'd4);
    chk("e_pc_hold", win_pc, 64'h2004);
    do_flush(64'h3000);
    chk("e_clr", 64'(err), 64'd0);
    chk("e_clr_wc", 64'(win_count), 64'd0);
    chk("e_clr_pc", win_pc, 64'h3000);

    tick;
    tick;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_req", 64'(req_valid), 64'd0);
    chk("mid_rst_pc", win_pc, 64'd0);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule
